// File: rtl/mem_access_stage.sv
// Memory stage of the RV32I pipeline: drives the req/ack data bus,
// stalls while an access is outstanding and registers MEM/WB.
module mem_access_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_M,
   input  logic        RegWrite_M,
   input  logic [1:0]  ResultSrc_M,
   input  logic        MemWrite_M,
   input  logic [2:0]  funct3_M,
   input  logic [31:0] ALUResult_M,
   input  logic [31:0] WriteData_M,
   input  logic [4:0]  Rd_M,
   input  logic [31:0] PCPlus4_M,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall_M,
   output logic        valid_W,
   output logic        RegWrite_W,
   output logic [1:0]  ResultSrc_W,
   output logic [31:0] ALUResult_W,
   output logic [31:0] ReadData_W,
   output logic [31:0] PCPlus4_W,
   output logic [4:0]  Rd_W,
   output logic [1:0]  exc_W
);
   localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

   typedef enum logic {IDLE, BUSY} state_t;
   state_t state;
   logic [7:0] cnt;

   logic        l_we, l_rw;
   logic [1:0]  l_rs;
   logic [2:0]  l_f3;
   logic [4:0]  l_rd;
   logic [3:0]  l_be;
   logic [31:0] l_alu, l_wdata, l_pc;

   logic        busy, mop, f3_ok, align_ok, illegal, legal, timeout, done;
   logic [3:0]  in_be;
   logic [31:0] in_wdata;

   always_comb begin
      mop = valid_M & (MemWrite_M | (ResultSrc_M == 2'b01));
      if (MemWrite_M)
         f3_ok = ~funct3_M[2] & (funct3_M[1:0] != 2'b11);
      else
         f3_ok = (funct3_M[1:0] != 2'b11) & ~(funct3_M[2] & funct3_M[1]);
      case (funct3_M[1:0])
         2'b10:   align_ok = (ALUResult_M[1:0] == 2'b00);
         2'b01:   align_ok = ~ALUResult_M[0];
         default: align_ok = 1'b1;
      endcase
      illegal = mop & ~(f3_ok & align_ok);
      legal   = mop & f3_ok & align_ok;
      case (funct3_M[1:0])
         2'b00: begin
            in_be    = 4'b0001 << ALUResult_M[1:0];
            in_wdata = {4{WriteData_M[7:0]}};
         end
         2'b01: begin
            in_be    = ALUResult_M[1] ? 4'b1100 : 4'b0011;
            in_wdata = {2{WriteData_M[15:0]}};
         end
         default: begin
            in_be    = 4'b1111;
            in_wdata = WriteData_M;
         end
      endcase
      if (!MemWrite_M) in_be = 4'b1111;
   end

   // BUSY drives the bus from the latched copy; ack beats timeout
   assign busy       = (state == BUSY);
   assign timeout    = busy & ~dmem_ack & (cnt == TMO);
   assign dmem_req   = ~rst & (busy ? ~timeout : legal);
   assign stall_M    = ~rst & ~dmem_ack & (busy ? ~timeout : legal);
   assign done       = dmem_req & dmem_ack;
   assign dmem_we    = busy ? l_we : MemWrite_M;
   assign dmem_addr  = busy ? {l_alu[31:2], 2'b00} : {ALUResult_M[31:2], 2'b00};
   assign dmem_wdata = busy ? l_wdata : in_wdata;
   assign dmem_be    = busy ? l_be : in_be;

   logic        x_we, x_rw;
   logic [1:0]  x_rs;
   logic [2:0]  x_f3;
   logic [4:0]  x_rd;
   logic [31:0] x_alu, x_pc, ext;
   logic [7:0]  b;
   logic [15:0] h;

   assign x_we  = busy ? l_we  : MemWrite_M;
   assign x_rw  = busy ? l_rw  : RegWrite_M;
   assign x_rs  = busy ? l_rs  : ResultSrc_M;
   assign x_f3  = busy ? l_f3  : funct3_M;
   assign x_rd  = busy ? l_rd  : Rd_M;
   assign x_alu = busy ? l_alu : ALUResult_M;
   assign x_pc  = busy ? l_pc  : PCPlus4_M;

   always_comb begin
      case (x_alu[1:0])
         2'b00:   b = dmem_rdata[7:0];
         2'b01:   b = dmem_rdata[15:8];
         2'b10:   b = dmem_rdata[23:16];
         default: b = dmem_rdata[31:24];
      endcase
      h = x_alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (x_f3)
         3'b000:  ext = {{24{b[7]}}, b};
         3'b100:  ext = {24'b0, b};
         3'b001:  ext = {{16{h[15]}}, h};
         3'b101:  ext = {16'b0, h};
         default: ext = dmem_rdata;
      endcase
   end

   logic        n_valid, n_rw;
   logic [1:0]  n_rs, n_exc;
   logic [4:0]  n_rd;
   logic [31:0] n_alu, n_rdata, n_pc;

   always_comb begin
      n_valid = valid_M;
      n_rw    = RegWrite_M;
      n_rs    = ResultSrc_M;
      n_rd    = Rd_M;
      n_alu   = ALUResult_M;
      n_pc    = PCPlus4_M;
      n_rdata = 32'b0;
      n_exc   = 2'b00;
      if (done || timeout) begin
         n_valid = 1'b1;
         n_rw    = done & x_rw;
         n_rs    = x_rs;
         n_rd    = x_rd;
         n_alu   = x_alu;
         n_pc    = x_pc;
         n_rdata = (done & ~x_we) ? ext : 32'b0;
         n_exc   = done ? 2'b00 : 2'b10;
      end else if (stall_M) begin
         // bubble into WB while the access is outstanding
         n_valid = 1'b0;
         n_rw    = 1'b0;
      end else if (illegal) begin
         n_valid = 1'b1;
         n_rw    = 1'b0;
         n_exc   = 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= 8'd0;
         valid_W     <= 1'b0;
         RegWrite_W  <= 1'b0;
         ResultSrc_W <= 2'b00;
         ALUResult_W <= 32'b0;
         ReadData_W  <= 32'b0;
         PCPlus4_W   <= 32'b0;
         Rd_W        <= 5'b0;
         exc_W       <= 2'b00;
      end else begin
         valid_W     <= n_valid;
         RegWrite_W  <= n_rw;
         ResultSrc_W <= n_rs;
         ALUResult_W <= n_alu;
         ReadData_W  <= n_rdata;
         PCPlus4_W   <= n_pc;
         Rd_W        <= n_rd;
         exc_W       <= n_exc;
         case (state)
            IDLE: if (legal) begin
               l_we    <= MemWrite_M;
               l_rw    <= RegWrite_M;
               l_rs    <= ResultSrc_M;
               l_f3    <= funct3_M;
               l_rd    <= Rd_M;
               l_be    <= in_be;
               l_alu   <= ALUResult_M;
               l_wdata <= in_wdata;
               l_pc    <= PCPlus4_M;
               cnt     <= 8'd1;
               if (!dmem_ack) state <= BUSY;
            end
            default: begin
               if (dmem_ack || timeout) state <= IDLE;
               else cnt <= cnt + 8'd1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed plus randomized bench for mem_access_stage with a
// transaction-level reference model.
module tb_mem_access_stage;
   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_M, RegWrite_M, MemWrite_M;
   logic [1:0]  ResultSrc_M;
   logic [2:0]  funct3_M;
   logic [31:0] ALUResult_M, WriteData_M, PCPlus4_M;
   logic [4:0]  Rd_M;
   logic        dmem_req, dmem_we, dmem_ack, stall_M;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        valid_W, RegWrite_W;
   logic [1:0]  ResultSrc_W, exc_W;
   logic [31:0] ALUResult_W, ReadData_W, PCPlus4_W;
   logic [4:0]  Rd_W;

   int checks = 0;
   int errors = 0;

   mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .valid_M(valid_M), .RegWrite_M(RegWrite_M),
      .ResultSrc_M(ResultSrc_M), .MemWrite_M(MemWrite_M),
      .funct3_M(funct3_M), .ALUResult_M(ALUResult_M),
      .WriteData_M(WriteData_M), .Rd_M(Rd_M), .PCPlus4_M(PCPlus4_M),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata), .stall_M(stall_M), .valid_W(valid_W),
      .RegWrite_W(RegWrite_W), .ResultSrc_W(ResultSrc_W),
      .ALUResult_W(ALUResult_W), .ReadData_W(ReadData_W),
      .PCPlus4_W(PCPlus4_W), .Rd_W(Rd_W), .exc_W(exc_W)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] w,
                                            input logic [2:0] f3,
                                            input logic [31:0] a);
      int nb = 1 << f3[1:0];
      logic [31:0] mask;
      logic [31:0] v = w >> (8 * (a % 4));
      if (nb < 4) begin
         mask = (32'd1 << (8 * nb)) - 32'd1;
         v = v & mask;
         if (!f3[2] && v[8 * nb - 1]) v = v | ~mask;
      end
      return v;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [31:0] wd,
                                             input int nb);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8 * i +: 8] = wd[8 * (i % nb) +: 8];
      return r;
   endfunction

   // One instruction: hold it until the stage stops stalling; the bus
   // acks after `waits` cycles (negative = never).
   task automatic run_op(input logic v, input logic rw,
                         input logic [1:0] rs, input logic mw,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdv,
                         input logic [4:0] rd, input int waits,
                         input string tag);
      bit mop, f3ok, illegal, legal, tout, s;
      int nb, exp_stall, stalls;
      logic [31:0] pc, e_rdata;
      logic [3:0] ebe;
      logic [1:0] e_exc;
      pc      = $urandom;
      nb      = 1 << f3[1:0];
      mop     = v && (mw || rs == 2'b01);
      f3ok    = mw ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      illegal = mop && (!f3ok || (a % nb) != 0);
      legal   = mop && !illegal;
      tout    = legal && (waits < 0 || waits > TMO);
      exp_stall = !legal ? 0 : (tout ? TMO : waits);
      ebe     = mw ? 4'(((1 << nb) - 1) << (a % 4)) : 4'hF;
      e_exc   = illegal ? 2'd1 : (tout ? 2'd2 : 2'd0);
      e_rdata = (legal && !mw && !tout) ? ref_load(rdv, f3, a) : 32'd0;

      valid_M = v; RegWrite_M = rw; ResultSrc_M = rs; MemWrite_M = mw;
      funct3_M = f3; ALUResult_M = a; WriteData_M = wd; Rd_M = rd;
      PCPlus4_M = pc; dmem_rdata = rdv;
      stalls = 0;
      for (int c = 0; c < 300; c++) begin
         dmem_ack = (waits >= 0 && c == waits);
         @(negedge clk);
         if (c == 0) begin
            chk({tag, ".req"}, 32'(dmem_req), 32'(legal));
            if (legal) begin
               chk({tag, ".we"}, 32'(dmem_we), 32'(mw));
               chk({tag, ".addr"}, dmem_addr, a & ~32'h3);
               chk({tag, ".be"}, 32'(dmem_be), 32'(ebe));
               if (mw) chk({tag, ".wdata"}, dmem_wdata, ref_wdata(wd, nb));
            end
         end
         if (tout && c == TMO) chk({tag, ".req_drop"}, 32'(dmem_req), 32'd0);
         s = stall_M;
         if (s) stalls++;
         @(posedge clk); #1;
         if (!s) break;
      end
      valid_M = 1'b0; MemWrite_M = 1'b0; ResultSrc_M = 2'b00;
      dmem_ack = 1'b0;
      chk({tag, ".stalls"}, 32'(stalls), 32'(exp_stall));
      chk({tag, ".valid_W"}, 32'(valid_W), 32'(v));
      chk({tag, ".rw_W"}, 32'(RegWrite_W), 32'(rw && e_exc == 2'd0));
      chk({tag, ".exc_W"}, 32'(exc_W), 32'(e_exc));
      chk({tag, ".alu_W"}, ALUResult_W, a);
      chk({tag, ".rdata_W"}, ReadData_W, e_rdata);
      chk({tag, ".rd_W"}, 32'(Rd_W), 32'(rd));
      chk({tag, ".pc_W"}, PCPlus4_W, pc);
      chk({tag, ".rs_W"}, 32'(ResultSrc_W), 32'(rs));
   endtask

   initial begin
      int kind, w;
      logic [31:0] addr;
      rst = 1'b1; valid_M = 1'b0; RegWrite_M = 1'b0; MemWrite_M = 1'b0;
      ResultSrc_M = 2'b00; funct3_M = 3'b000; ALUResult_M = 32'd0;
      WriteData_M = 32'd0; Rd_M = 5'd0; PCPlus4_M = 32'd0;
      dmem_ack = 1'b0; dmem_rdata = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.req", 32'(dmem_req), 32'd0);
      chk("rst.stall", 32'(stall_M), 32'd0);
      chk("rst.ctl_W", {valid_W, RegWrite_W, ResultSrc_W, exc_W, Rd_W}, 32'd0);
      chk("rst.data_W", ALUResult_W | ReadData_W | PCPlus4_W, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_op(1, 1, 2'b00, 0, 3'b000, 32'h1234, 0, 0, 5'd5, 0, "alu");
      run_op(1, 0, 2'b00, 1, 3'b000, 32'h1003, 32'hAABBCCDD, 0, 5'd0, 0, "sb");
      run_op(1, 1, 2'b01, 0, 3'b000, 32'h2001, 0, 32'h80FF, 5'd7, 3, "lb");
      run_op(1, 1, 2'b01, 0, 3'b100, 32'h2001, 0, 32'h80FF, 5'd8, 3, "lbu");
      run_op(1, 1, 2'b01, 0, 3'b010, 32'h2002, 0, 0, 5'd9, 0, "lw_mis");
      run_op(1, 0, 2'b00, 1, 3'b001, 32'h3001, 32'h55, 0, 5'd0, 0, "sh_mis");
      run_op(1, 1, 2'b01, 0, 3'b010, 32'h2000, 0, 32'hDEAD, 5'd3, -1, "lw_tmo");
      run_op(1, 1, 2'b01, 0, 3'b101, 32'h2002, 0, 32'h9876_0000, 5'd4, TMO, "lhu_edge");
      run_op(1, 1, 2'b01, 0, 3'b011, 32'h2000, 0, 0, 5'd2, 0, "ld_bad_f3");
      run_op(0, 1, 2'b01, 0, 3'b010, 32'h2000, 0, 0, 5'd1, 0, "ld_invalid");

      // reset while an access is outstanding
      valid_M = 1'b1; RegWrite_M = 1'b1; ResultSrc_M = 2'b01;
      MemWrite_M = 1'b0; funct3_M = 3'b010; ALUResult_M = 32'h4000;
      dmem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rstbusy.req", 32'(dmem_req), 32'd0);
      chk("rstbusy.stall", 32'(stall_M), 32'd0);
      @(posedge clk); #1;
      valid_M = 1'b0; ResultSrc_M = 2'b00;
      rst = 1'b0;
      chk("rstbusy.ctl_W", {valid_W, RegWrite_W, ResultSrc_W, exc_W, Rd_W}, 32'd0);
      chk("rstbusy.data_W", ALUResult_W | ReadData_W | PCPlus4_W, 32'd0);
      run_op(1, 1, 2'b01, 0, 3'b001, 32'h5002, 0, 32'h8001_1234, 5'd6, 1, "post_rst");

      for (int i = 0; i < 80; i++) begin
         kind = int'($urandom_range(0, 2));
         w    = int'($urandom_range(0, 7)) - 1;
         addr = $urandom;
         if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
         case (kind)
            0: run_op($urandom_range(0, 9) != 0, 1'($urandom), 2'b00, 0,
                      3'($urandom), addr, $urandom, $urandom, 5'($urandom),
                      w, "rnd_alu");
            1: run_op($urandom_range(0, 9) != 0, 1'($urandom), 2'b01, 0,
                      3'($urandom), addr, $urandom, $urandom, 5'($urandom),
                      w, "rnd_ld");
            default: run_op($urandom_range(0, 9) != 0, 1'b0, 2'b00, 1,
                      3'($urandom), addr, $urandom, $urandom, 5'($urandom),
                      w, "rnd_st");
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
